// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: denomination values and indices,
// FSM state encoding and the default amount width.
package vm_pkg;

    localparam int DEFAULT_AMT_W = 8;
    localparam int NUM_DENOM     = 4;

    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;
    localparam int VAL_20 = 20;
    localparam int VAL_50 = 50;

    typedef logic [1:0] denom_idx_t;

    localparam denom_idx_t IDX_5  = 2'd0;
    localparam denom_idx_t IDX_10 = 2'd1;
    localparam denom_idx_t IDX_20 = 2'd2;
    localparam denom_idx_t IDX_50 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_EJECT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int denom_value(input denom_idx_t idx);
        case (idx)
            IDX_5:   return VAL_5;
            IDX_10:  return VAL_10;
            IDX_20:  return VAL_20;
            default: return VAL_50;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters for the change dispenser: bulk refill, one
// indexed decrement per cycle, and nonzero/empty flags per denomination.
module coin_inventory
    import vm_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_refill,
    input  logic                 i_dec,
    input  denom_idx_t           i_dec_idx,
    output logic [NUM_DENOM-1:0] o_nonzero,
    output logic [NUM_DENOM-1:0] o_empty
);

    logic [NUM_DENOM-1:0][CNT_W-1:0] r_cnt;

    // NOTE: the counters are architectural state, so unlike a data memory they
    // must be reset; refill shares the same load path.
    always_ff @(posedge clk) begin
        if (reset || i_refill) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                r_cnt[i] <= CNT_W'(INIT_COUNT);
            end
        end else if (i_dec) begin
            r_cnt[i_dec_idx] <= r_cnt[i_dec_idx] - CNT_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            o_nonzero[i] = |r_cnt[i];
        end
        o_empty = ~o_nonzero;
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return sequencer: greedy 50/20/10/5 ejection under a hopper ack handshake.
// Optional macro ACK_TIMEOUT_EN adds a hopper ack timeout with a sticky jam flag.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W          = DEFAULT_AMT_W,
    parameter int CNT_W          = 4,
    parameter int INIT_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             hopper_ack,
    output logic             eject_5,
    output logic             eject_10,
    output logic             eject_20,
    output logic             eject_50,
    input  logic             refill,
    output logic [3:0]       coin_empty,
    output logic             done,
    output logic             done_short,
    output logic [AMT_W-1:0] owed,
    output logic             jam
);

    state_t           r_state;
    state_t           w_next;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] r_owed;
    logic             r_short;
    denom_idx_t       r_sel;
    denom_idx_t       w_pick_idx;
    logic             w_pick_found;
    logic [AMT_W-1:0] w_sel_val;
    logic [3:0]       w_nonzero;
    logic             w_refill_ok;
    logic             w_dec;

    assign w_refill_ok = refill && (r_state == ST_IDLE);
    assign w_dec       = hopper_ack && (r_state == ST_EJECT);
    assign w_sel_val   = AMT_W'(denom_value(r_sel));

    coin_inventory #(
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inv (
        .clk       (clk),
        .reset     (reset),
        .i_refill  (w_refill_ok),
        .i_dec     (w_dec),
        .i_dec_idx (r_sel),
        .o_nonzero (w_nonzero),
        .o_empty   (coin_empty)
    );

`ifdef ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_jam;
    logic             w_timeout;

    // An ack in the last counted cycle takes priority over the timeout.
    assign w_timeout = (r_state == ST_EJECT) && !hopper_ack &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_jam     <= 1'b0;
        end else begin
            if (r_state != ST_EJECT) begin
                r_tmo_cnt <= '0;
            end else if (!hopper_ack) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_timeout) begin
                r_jam <= 1'b1;
            end else if (w_refill_ok) begin
                r_jam <= 1'b0;
            end
        end
    end

    assign jam = r_jam;
`else
    assign jam = 1'b0;
`endif

    // Largest affordable denomination that is still in stock.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = IDX_5;
        if (r_remaining >= AMT_W'(VAL_50) && w_nonzero[IDX_50]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = IDX_50;
        end else if (r_remaining >= AMT_W'(VAL_20) && w_nonzero[IDX_20]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = IDX_20;
        end else if (r_remaining >= AMT_W'(VAL_10) && w_nonzero[IDX_10]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = IDX_10;
        end else if (r_remaining >= AMT_W'(VAL_5) && w_nonzero[IDX_5]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = IDX_5;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_next = ST_PICK;
            end
            ST_PICK: begin
                w_next = w_pick_found ? ST_EJECT : ST_DONE;
            end
            ST_EJECT: begin
                if (hopper_ack) w_next = ST_PICK;
`ifdef ACK_TIMEOUT_EN
                else if (w_timeout) w_next = ST_DONE;
`endif
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
            r_owed      <= '0;
            r_short     <= 1'b0;
            r_sel       <= IDX_5;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_remaining <= req_amount;
                        r_owed      <= '0;
                        r_short     <= 1'b0;
                    end
                end
                ST_PICK: begin
                    r_sel <= w_pick_idx;
                    if (!w_pick_found) begin
                        r_short <= (r_remaining != '0);
                        r_owed  <= r_remaining;
                    end
                end
                ST_EJECT: begin
                    if (hopper_ack) begin
                        r_remaining <= r_remaining - w_sel_val;
                    end
`ifdef ACK_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_short <= 1'b1;
                        r_owed  <= r_remaining;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        done       = (r_state == ST_DONE);
        done_short = (r_state == ST_DONE) && r_short;
        owed       = r_owed;
        eject_5    = 1'b0;
        eject_10   = 1'b0;
        eject_20   = 1'b0;
        eject_50   = 1'b0;
        if (r_state == ST_EJECT) begin
            case (r_sel)
                IDX_5:   eject_5  = 1'b1;
                IDX_10:  eject_10 = 1'b1;
                IDX_20:  eject_20 = 1'b1;
                default: eject_50 = 1'b1;
            endcase
        end
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences the coin-return hopper after a sale: accepts a change amount, ejects coins greedily (50, 20, 10, 5), one coin at a time, under a hopper ack handshake.
- Keeps a per-denomination coin inventory and skips denominations that are empty.
- Reports either exact completion or a short-change result with the amount still owed.
- Sits between the product/credit controller (requester) and the physical coin hopper.

Parameters:
- AMT_W, 8: width of change amount and owed amount.
- CNT_W, 4: width of each coin inventory counter.
- INIT_COUNT, 4: coins per denomination after reset or refill; must be ≤ 2^CNT_W−1.
- TIMEOUT_CYCLES, 16: hopper ack timeout; used only with ACK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  change request valid.
- req_amount  in  AMT_W  change to return, in currency units.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- hopper_ack  in  1  hopper confirms one coin ejected.
- eject_5, eject_10, eject_20, eject_50  out  1 each  one-hot eject command, held until ack.
- refill  in  1  restore all counters to INIT_COUNT (honoured in IDLE only).
- coin_empty  out  4  bit0=5, bit1=10, bit2=20, bit3=50; high when that counter is 0.
- done  out  1  one-cycle completion pulse.
- done_short  out  1  valid with done; 1 = change not fully paid.
- owed  out  AMT_W  unpaid remainder; updated at done, held until next accept.
- jam  out  1  sticky hopper-timeout fault (ACK_TIMEOUT_EN only).

Behaviour:
- Reset (synchronous):
  - State goes to IDLE; all counters set to INIT_COUNT.
  - All eject, done, done_short, jam outputs 0; owed 0; remaining 0.
  - req_ready reads 1 from the first cycle after reset deasserts.
  - Reset mid-transaction drops eject on the same edge and discards the request.
- FSM states: IDLE, PICK, EJECT, DONE.
- IDLE:
  - On accept, latch remaining = req_amount; go to PICK.
  - refill, if asserted, reloads the counters in the same cycle. When refill and accept coincide, PICK sees the refilled counts.
- PICK (one cycle, no outputs):
  - remaining == 0: go to DONE with done_short=0, owed=0.
  - Otherwise select the largest d in {50,20,10,5} with d ≤ remaining and cnt_d > 0; go to EJECT.
  - No candidate (inventory exhausted, or remaining < 5 / not a multiple of 5): go to DONE with done_short=1, owed=remaining.
- EJECT:
  - The selected eject_d is high for every cycle in this state.
  - On hopper_ack: cnt_d −1, remaining −d, go to PICK. eject_d is low in the next cycle.
  - The decrement never underflows (PICK guarantees cnt_d > 0). The subtraction never wraps (d ≤ remaining).
- DONE: done=1 for exactly one cycle, then IDLE.
- Ignored inputs:
  - hopper_ack outside EJECT.
  - refill outside IDLE.
  - req_valid outside IDLE; it is not accepted, and the requester must hold it.
- coin_empty is combinational from the counters.
- Latency example (amount 15, full stock):
  - accept at T
  - eject_10 high T+2, ack T+2
  - eject_5 high T+4, ack T+4
  - done at T+6

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on EJECT entry.
  - If TIMEOUT_CYCLES consecutive EJECT cycles pass without ack: eject drops, no decrement, go to DONE with done_short=1, owed=remaining, and jam set.
  - jam clears only on reset or an honoured refill.
  - An ack arriving in the final counted cycle wins over the timeout.
- Undefined: EJECT waits indefinitely; jam tied 0; no timeout counter logic.

Decomposition:
- Shared package vm_pkg:
  - Denomination value constants (5, 10, 20, 50).
  - 2-bit denomination index typedef plus index constants.
  - FSM state enum.
  - Amount width constant.
- Sub-module coin_inventory:
  - Four CNT_W counters with refill, an indexed decrement, and per-denomination nonzero/empty flags.
  - Instantiated once.

Test Plan:
- Reset, then request 15 → eject_10 then eject_5 (one ack each), done=1, done_short=0, owed=0; counts 50:4, 20:4, 10:3, 5:3.
- Request 85 with full stock → ejects 50, 20, 10, 5 in that order; done_short=0.
- Five requests of 50 → fifth run picks 20, 20, 10; 50-counter 0; coin_empty[3]=1.
- Inventory drained so only one 5 remains, then request 20 → one eject_5, done_short=1, owed=15. Then refill in IDLE → all counts 4, coin_empty=0.
- Request 7 → eject_5 once, done_short=1, owed=2. Ack pulses in IDLE/PICK → no count change. refill during EJECT → ignored.
- ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16: request 10, ack withheld → eject_10 high exactly 16 cycles, done_short=1, owed=10, jam=1, 10-count unchanged. Reset asserted mid-EJECT in another run → eject low next edge, state IDLE.
